// File: rtl/soct_status_serializer.sv
// Serial status read-out port: latches status_in on an xlat fall and shifts it out on sck edges.
// Optional SOCT_PARITY_EN appends an even-parity bit after the last data bit.
module soct_status_serializer #(
    parameter int WIDTH       = 18,
    parameter bit MSB_FIRST   = 1'b1,
    parameter bit SHIFT_EDGE  = 1'b0,
    parameter int SYNC_STAGES = 2,
    parameter bit FILL_BIT    = 1'b0
) (
    input  logic                         sclk,
    input  logic                         rst_n,
    input  logic                         xlat,
    input  logic                         sck,
    input  logic [WIDTH-1:0]             status_in,
    output logic                         sdo,
`ifdef SOCT_PARITY_EN
    output logic [$clog2(WIDTH+3)-1:0]   bit_cnt,
`else
    output logic [$clog2(WIDTH+2)-1:0]   bit_cnt,
`endif
    output logic                         word_done,
    output logic                         overrun,
    output logic                         load_stb
);

`ifdef SOCT_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif
    localparam int            CW        = $clog2(SW + 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SW - 1);
    localparam logic [CW-1:0] CNT_EMPTY = CW'(SW);
    localparam logic [CW-1:0] CNT_SAT   = CW'(SW + 1);
    localparam logic          SCK_IDLE  = !SHIFT_EDGE;

    logic [SYNC_STAGES-1:0] xlat_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic                   xlat_prev;
    logic                   sck_prev;
    logic                   xlat_s;
    logic                   sck_s;
    logic                   load;
    logic                   shift;
    logic [SW-1:0]          load_word;
    logic [SW-1:0]          shifter;

    // Chains reset to the idle levels so releasing rst_n never looks like an edge.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            xlat_sync <= '1;
            xlat_prev <= 1'b1;
            sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
            sck_prev  <= SCK_IDLE;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            xlat_sync <= {xlat_sync[SYNC_STAGES-2:0], xlat};
            xlat_prev <= xlat_sync[SYNC_STAGES-1];
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            sck_prev  <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign xlat_s = xlat_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign load   = xlat_prev && !xlat_s;
    assign shift  = (sck_s == SHIFT_EDGE) && (sck_prev != SHIFT_EDGE) && !load;

    // Word image arranged so that the first bit to leave sits in the top of the shifter.
    always_comb begin
        // NOTE: default assignment first so no path through the block infers a latch.
        load_word = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_word[SW-1-i] = MSB_FIRST ? status_in[WIDTH-1-i] : status_in[i];
        end
`ifdef SOCT_PARITY_EN
        load_word[0] = ^status_in;
`endif
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            shifter   <= '0;
            sdo       <= 1'b0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            overrun   <= 1'b0;
            load_stb  <= 1'b0;
        end else begin
            load_stb  <= load;
            word_done <= shift && (bit_cnt == CNT_LAST);
            sdo       <= shifter[SW-1];
            if (load) begin
                shifter <= load_word;
                bit_cnt <= '0;
                overrun <= 1'b0;
            end else if (shift) begin
                shifter <= {shifter[SW-2:0], FILL_BIT};
                if (bit_cnt != CNT_SAT) begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
                if (bit_cnt >= CNT_EMPTY) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_soct_status_serializer.sv
// Bench for soct_status_serializer: two instances (MSB-first and LSB-first) driven by one host.
// A word/bit-index model predicts sdo, bit_cnt, overrun and pulse counts once outputs settle.
module tb_soct_status_serializer;

    localparam int WIDTH       = 18;
    localparam int SYNC_STAGES = 2;
`ifdef SOCT_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif
    localparam int   CW     = $clog2(SW + 2);
    localparam int   SETTLE = SYNC_STAGES + 4;
    localparam int   PHASE  = SYNC_STAGES + 6;
    localparam logic FILL   = 1'b0;

    logic             sclk = 1'b0;
    logic             rst_n = 1'b1;
    logic             xlat = 1'b1;
    logic             sck = 1'b1;
    logic [WIDTH-1:0] status_in = '0;
    logic             sdo_m, sdo_l, done_m, done_l, ovr_m, ovr_l, ld_m, ld_l;
    logic [CW-1:0]    cnt_m, cnt_l;

    always #5 sclk = ~sclk;

    soct_status_serializer #(
        .WIDTH(WIDTH), .MSB_FIRST(1'b1), .SHIFT_EDGE(1'b0),
        .SYNC_STAGES(SYNC_STAGES), .FILL_BIT(FILL)
    ) dut_msb (
        .sclk(sclk), .rst_n(rst_n), .xlat(xlat), .sck(sck), .status_in(status_in),
        .sdo(sdo_m), .bit_cnt(cnt_m), .word_done(done_m), .overrun(ovr_m), .load_stb(ld_m)
    );

    soct_status_serializer #(
        .WIDTH(WIDTH), .MSB_FIRST(1'b0), .SHIFT_EDGE(1'b0),
        .SYNC_STAGES(SYNC_STAGES), .FILL_BIT(FILL)
    ) dut_lsb (
        .sclk(sclk), .rst_n(rst_n), .xlat(xlat), .sck(sck), .status_in(status_in),
        .sdo(sdo_l), .bit_cnt(cnt_l), .word_done(done_l), .overrun(ovr_l), .load_stb(ld_l)
    );

    // Model: the latched word, how many shifts the host has issued, expected pulse totals.
    logic [WIDTH-1:0] mdl_word = '0;
    int               mdl_n = 0;
    int               mdl_loads = 0;
    int               mdl_dones = 0;
    int               seen_loads_m = 0, seen_loads_l = 0, seen_dones_m = 0, seen_dones_l = 0;
    logic             prev_done_m = 1'b0, prev_done_l = 1'b0;
    logic             check_en = 1'b0;
    int               n_cmp = 0;
    int               n_bad = 0;

    function automatic logic mdl_bit(input bit lsb_first, input int idx);
        if (idx >= SW) return FILL;
        if (idx == WIDTH) return ^mdl_word;
        return lsb_first ? mdl_word[idx] : mdl_word[WIDTH-1-idx];
    endfunction

    function automatic int mdl_cnt();
        return (mdl_n > SW + 1) ? SW + 1 : mdl_n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // Pulse monitor and per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge sclk);
            if (rst_n) begin
                if (ld_m) seen_loads_m++;
                if (ld_l) seen_loads_l++;
                if (done_m) begin
                    seen_dones_m++;
                    check("done_m_width", 64'(prev_done_m), 64'h0);
                end
                if (done_l) begin
                    seen_dones_l++;
                    check("done_l_width", 64'(prev_done_l), 64'h0);
                end
            end
            prev_done_m = done_m;
            prev_done_l = done_l;
            if (check_en) begin
                check("sdo_m", 64'(sdo_m), 64'(mdl_bit(1'b0, mdl_n)));
                check("sdo_l", 64'(sdo_l), 64'(mdl_bit(1'b1, mdl_n)));
                check("cnt_m", 64'(cnt_m), 64'(mdl_cnt()));
                check("cnt_l", 64'(cnt_l), 64'(mdl_cnt()));
                check("ovr_m", 64'(ovr_m), 64'(mdl_n > SW));
                check("ovr_l", 64'(ovr_l), 64'(mdl_n > SW));
                check("loads_m", 64'(seen_loads_m), 64'(mdl_loads));
                check("loads_l", 64'(seen_loads_l), 64'(mdl_loads));
                check("dones_m", 64'(seen_dones_m), 64'(mdl_dones));
                check("dones_l", 64'(seen_dones_l), 64'(mdl_dones));
            end
        end
    end

    task automatic wait_cycles(input int c);
        repeat (c) @(posedge sclk);
        #1;
    endtask

    task automatic host_load(input logic [WIDTH-1:0] w);
        status_in = w;
        wait_cycles(1);
        check_en  = 1'b0;
        xlat      = 1'b0;
        mdl_word  = w;
        mdl_n     = 0;
        mdl_loads++;
        wait_cycles(SETTLE);
        status_in = ~w;
        check_en  = 1'b1;
        wait_cycles(PHASE - SETTLE);
        xlat = 1'b1;
        wait_cycles(PHASE);
    endtask

    task automatic host_shift();
        check_en = 1'b0;
        sck      = 1'b0;
        if (mdl_n == SW - 1) mdl_dones++;
        mdl_n++;
        wait_cycles(SETTLE);
        check_en = 1'b1;
        wait_cycles(PHASE - SETTLE);
        sck = 1'b1;
        wait_cycles(PHASE);
    endtask

    task automatic host_load_and_shift(input logic [WIDTH-1:0] w);
        status_in = w;
        wait_cycles(1);
        check_en = 1'b0;
        xlat     = 1'b0;
        sck      = 1'b0;
        mdl_word = w;
        mdl_n    = 0;
        mdl_loads++;
        wait_cycles(SETTLE);
        check_en = 1'b1;
        wait_cycles(PHASE - SETTLE);
        xlat = 1'b1;
        sck  = 1'b1;
        wait_cycles(PHASE);
    endtask

    task automatic host_reset();
        check_en = 1'b0;
        rst_n    = 1'b0;
        mdl_word = '0;
        mdl_n    = 0;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(SETTLE);
        check_en = 1'b1;
    endtask

    initial begin
        logic [SW-1:0] coll_m;
        logic [SW-1:0] coll_l;
        int            done0;
        int            load0;

        #2 rst_n = 1'b0;
        wait_cycles(4);
        rst_n    = 1'b1;
        check_en = 1'b1;

        // Idle after reset
        wait_cycles(100);
        check("t1_loads", 64'(seen_loads_m), 64'h0);
        check("t1_cnt", 64'(cnt_m), 64'h0);
        check("t1_sdo", 64'(sdo_m), 64'h0);

        // Full word read-out on both bit orders
        host_load(18'h2A5C3);
        done0  = seen_dones_m;
        coll_m = '0;
        coll_l = '0;
        for (int k = 0; k < SW; k++) begin
            coll_m = {coll_m[SW-2:0], sdo_m};
            coll_l = {coll_l[SW-2:0], sdo_l};
            host_shift();
        end
`ifdef SOCT_PARITY_EN
        check("t2_seq_m", 64'(coll_m), 64'h54B87);
        check("t2_seq_l", 64'(coll_l), 64'h61D2B);
        check("t2_cnt", 64'(cnt_m), 64'd19);
`else
        check("t2_seq_m", 64'(coll_m), 64'h2A5C3);
        check("t2_seq_l", 64'(coll_l), 64'h30E95);
        check("t2_cnt", 64'(cnt_m), 64'd18);
`endif
        check("t2_done", 64'(seen_dones_m - done0), 64'd1);
        check("t2_ovr", 64'(ovr_m), 64'h0);

        // Reading past the end: fill bits, overrun, saturation
        host_shift();
        host_shift();
`ifdef SOCT_PARITY_EN
        check("t4_cnt", 64'(cnt_m), 64'd20);
`else
        check("t4_cnt", 64'(cnt_m), 64'd19);
`endif
        check("t4_ovr", 64'(ovr_l), 64'h1);
        check("t4_sdo", 64'(sdo_m), 64'(FILL));
        check("t4_done", 64'(seen_dones_m - done0), 64'd1);
        host_load(18'h2A5C3);
        check("t4_reload_cnt", 64'(cnt_m), 64'h0);
        check("t4_reload_ovr", 64'(ovr_m), 64'h0);
        check("t4_reload_sdo_m", 64'(sdo_m), 64'h1);
        check("t4_reload_sdo_l", 64'(sdo_l), 64'h1);

        // Load and shift detected in the same cycle
        repeat (5) host_shift();
        host_load_and_shift(18'h20000);
        check("t5_cnt", 64'(cnt_l), 64'h0);
        check("t5_sdo_m", 64'(sdo_m), 64'h1);
        check("t5_sdo_l", 64'(sdo_l), 64'h0);
        host_shift();
        check("t5_next_sdo_m", 64'(sdo_m), 64'h0);
        check("t5_next_cnt", 64'(cnt_m), 64'h1);

        // Reset in the middle of a word, then a clean word
        repeat (3) host_shift();
        host_reset();
        check("t7_cnt", 64'(cnt_m), 64'h0);
        check("t7_sdo", 64'(sdo_m), 64'h0);
        host_load(18'h15555);
        repeat (SW + 1) host_shift();

        // Back-to-back loads without reading: the last word wins
        load0 = seen_loads_m;
        host_load(18'h3FFFF);
        host_load(18'h00F0F);
        check("t8_loads", 64'(seen_loads_m - load0), 64'd2);
        check("t8_sdo_l", 64'(sdo_l), 64'h1);
        check("t8_sdo_m", 64'(sdo_m), 64'h0);
        repeat (SW) host_shift();

`ifdef SOCT_PARITY_EN
        // Parity bit follows the data
        host_load(18'h00007);
        done0  = seen_dones_m;
        coll_m = '0;
        coll_l = '0;
        for (int k = 0; k < SW - 1; k++) begin
            coll_m = {coll_m[SW-2:0], sdo_m};
            coll_l = {coll_l[SW-2:0], sdo_l};
            host_shift();
        end
        check("t6_done_early", 64'(seen_dones_m - done0), 64'd0);
        check("t6_parity_bit", 64'(sdo_m), 64'h1);
        coll_m = {coll_m[SW-2:0], sdo_m};
        coll_l = {coll_l[SW-2:0], sdo_l};
        host_shift();
        check("t6_done", 64'(seen_dones_m - done0), 64'd1);
        check("t6_seq_m", 64'(coll_m), 64'h0000F);
        check("t6_seq_l", 64'(coll_l), 64'h70001);
`endif

        wait_cycles(4);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

endmodule
